// File: rtl/injector_bank_pnh.sv
// N-channel peak-and-hold injector driver: staggered hold-chop strobes, one FSM per channel,
// peak-timeout fault latch and fixed-length fast-decay turn-off.
module injector_bank_pnh #(
  parameter int N_CH              = 4,
  parameter int PERIOD_CYCLES     = 1000,
  parameter int PEAK_TIMEOUT      = 4000,
  parameter int FAST_DECAY_CYCLES = 50
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [N_CH-1:0] i_enable,
  input  logic [N_CH-1:0] i_peak,
  input  logic [N_CH-1:0] i_hold,
  input  logic [N_CH-1:0] i_fault_clr,
  output logic [N_CH-1:0] o_drive,
  output logic [N_CH-1:0] o_flyback,
  output logic [N_CH-1:0] o_fault,
  output logic [N_CH-1:0] o_busy
);

  localparam int CNT_W   = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
  localparam int TMR_MAX = (PEAK_TIMEOUT > FAST_DECAY_CYCLES) ? PEAK_TIMEOUT : FAST_DECAY_CYCLES;
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(PERIOD_CYCLES - 1);
  localparam logic [TMR_W-1:0] PEAK_LAST  = TMR_W'(PEAK_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] DECAY_LAST = TMR_W'(FAST_DECAY_CYCLES - 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_PEAK     = 3'd1;
  localparam logic [2:0] S_HOLD_OFF = 3'd2;
  localparam logic [2:0] S_HOLD_ON  = 3'd3;
  localparam logic [2:0] S_DECAY    = 3'd4;
  localparam logic [2:0] S_FAULT    = 3'd5;

  logic [CNT_W-1:0] m_cnt;

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      m_cnt <= '0;
    end else if (m_cnt == CNT_LAST) begin
      m_cnt <= '0;
    end else begin
      m_cnt <= m_cnt + CNT_W'(1);
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    // Channel k's chop slot sits k/N_CH of the way through the period.
    localparam logic [CNT_W-1:0] OFFSET = CNT_W'((k * PERIOD_CYCLES) / N_CH);

    logic             strobe;
    logic [2:0]       state;
    logic [2:0]       state_nx;
    logic [TMR_W-1:0] timer;
    logic [TMR_W-1:0] timer_nx;
    logic             drive_q;
    logic             fly_q;
    logic             fault_q;
    logic             busy_q;

    assign strobe = (m_cnt == OFFSET);

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
      state_nx = state;
      case (state)
        S_IDLE: begin
          if (i_enable[k]) state_nx = S_PEAK;
        end
        S_PEAK: begin
          if (!i_enable[k])                          state_nx = S_DECAY;
          else if (timer == PEAK_LAST && !i_peak[k]) state_nx = S_FAULT;
          else if (i_peak[k])                        state_nx = S_HOLD_OFF;
        end
        S_HOLD_OFF: begin
          if (!i_enable[k])            state_nx = S_DECAY;
          else if (strobe && !i_hold[k]) state_nx = S_HOLD_ON;
        end
        S_HOLD_ON: begin
          if (!i_enable[k])  state_nx = S_DECAY;
          else if (i_hold[k]) state_nx = S_HOLD_OFF;
        end
        S_DECAY: begin
          if (timer == DECAY_LAST) state_nx = S_IDLE;
        end
        S_FAULT: begin
          if (i_fault_clr[k] && !i_enable[k]) state_nx = S_IDLE;
        end
        default: state_nx = S_IDLE;
      endcase
    end

    // One timer serves both PEAK and DECAY; it restarts from 0 on every state change.
    always_comb begin
      timer_nx = '0;
      if (state_nx == state && (state == S_PEAK || state == S_DECAY)) begin
        timer_nx = timer + TMR_W'(1);
      end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        state   <= S_IDLE;
        timer   <= '0;
        drive_q <= 1'b0;
        fly_q   <= 1'b0;
        fault_q <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        state   <= state_nx;
        timer   <= timer_nx;
        drive_q <= (state_nx == S_PEAK) || (state_nx == S_HOLD_ON);
        fly_q   <= (state_nx == S_HOLD_OFF) || (state_nx == S_HOLD_ON);
        fault_q <= (state_nx == S_FAULT);
        busy_q  <= (state_nx == S_PEAK) || (state_nx == S_HOLD_OFF) ||
                   (state_nx == S_HOLD_ON) || (state_nx == S_DECAY);
      end
    end

    assign o_drive[k]   = drive_q;
    assign o_flyback[k] = fly_q;
    assign o_fault[k]   = fault_q;
    assign o_busy[k]    = busy_q;
  end

endmodule
